// File: rtl/fp_round_pack.sv
// fp_round_pack: normalizes a 27-bit extended mantissa one shift per cycle,
// rounds to nearest-even and packs an IEEE-754 single behind a valid/ready
// output handshake. One operation in flight at a time.
module fp_round_pack #(
  parameter int MAX_EXP  = 255,
  parameter int BIAS_MIN = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic        in_carry,
  input  logic [26:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_zero
);

  localparam logic [7:0] EXP_MAX = 8'(MAX_EXP);
  localparam logic [7:0] EXP_MIN = 8'(BIAS_MIN);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic        carry_q;
  logic [26:0] mant_q;
  logic        inf_q;
  logic [31:0] res_q;
  logic        ovf_q;
  logic        zero_q;

  logic        inc;
  logic [24:0] sum;
  logic [8:0]  exp_rnd;
  logic [22:0] frac;
  logic [7:0]  exp_fld;
  logic        rnd_ovf;

  assign in_ready = (state == IDLE);

  // Round-to-nearest-even on the normalized mantissa; a denormal (hidden
  // bit clear) takes exponent field 1 only if rounding carried into bit 23.
  always_comb begin
    inc     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    sum     = {1'b0, mant_q[26:3]} + {24'd0, inc};
    exp_rnd = {1'b0, exp_q} + {8'd0, sum[24]};
    frac    = sum[24] ? 23'd0 : sum[22:0];
    exp_fld = mant_q[26] ? exp_rnd[7:0] : {7'd0, sum[23]};
    rnd_ovf = inf_q | (exp_rnd >= {1'b0, EXP_MAX});
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      sign_q       <= 1'b0;
      exp_q        <= 8'd0;
      carry_q      <= 1'b0;
      mant_q       <= 27'd0;
      inf_q        <= 1'b0;
      res_q        <= 32'd0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= 32'd0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= (in_exp == 8'd0) ? 8'd1 : in_exp;
            carry_q <= in_carry;
            mant_q  <= in_mant;
            inf_q   <= 1'b0;
            state   <= NORM;
          end
        end
        NORM: begin
          if (exp_q == EXP_MAX) begin
            inf_q <= 1'b1;
            state <= ROUND;
          end else if (carry_q) begin
            // Shift right folding the dropped bit into sticky.
            mant_q  <= {1'b1, mant_q[26:2], mant_q[1] | mant_q[0]};
            exp_q   <= exp_q + 8'd1;
            carry_q <= 1'b0;
          end else if (mant_q == 27'd0) begin
            res_q  <= {sign_q, 31'd0};
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
            state  <= DONE;
          end else if (mant_q[26] || exp_q == EXP_MIN) begin
            state <= ROUND;
          end else begin
            mant_q <= {mant_q[25:0], 1'b0};
            exp_q  <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          res_q  <= rnd_ovf ? {sign_q, 8'hFF, 23'd0} : {sign_q, exp_fld, frac};
          ovf_q  <= rnd_ovf;
          zero_q <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          // Present the result on the first DONE cycle, then hold until taken.
          if (!out_valid) begin
            out_valid    <= 1'b1;
            out_result   <= res_q;
            out_overflow <= ovf_q;
            out_zero     <= zero_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
